sdram_rr_arbiter: RTL and testbench

//  Two-master round-robin Avalon-MM arbiter sharing the single SDRAM controller slave port.
//  m0 = CNN weight/feature fetch; m1 = result writeback / Nios data.

---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/sdram_rd_tag_fifo.sv | 55 +++++
 rtl/sdram_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_rr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the two-master SDRAM round-robin arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF   = 24;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_PEND_DEF = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  // Identifies which master issued a read: 0 = m0, 1 = m1.
  typedef logic master_id_t;

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// Synchronous FIFO of 1-bit master IDs, one entry per outstanding SDRAM read.
module sdram_rd_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_PEND_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  master_id_t       din_i,
  input  logic             pop_i,
  output master_id_t       dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  // NOTE: storage has no reset; only pointers and count need one, so the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin Avalon-MM arbiter: two masters share one SDRAM controller port,
// read returns are steered back to the issuer via an ID FIFO.
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic                clock_clk,
  input  logic                clock_sreset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan
);

  localparam int CNT_W = $clog2(MAX_PEND) + 1;
  localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(MAX_PEND - 1);

  logic [1:0]       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             err_q;
  logic             fifo_full, fifo_empty, push, pop, accept, full_after;
  logic [CNT_W-1:0] fifo_count;
  master_id_t       head_id;
  logic             gnt1, gnt_any, sel_read, sel_write, oth_read, oth_write;
  logic             m0_elig, m1_elig, oth_elig_after;

  sdram_rd_tag_fifo #(.DEPTH(MAX_PEND), .CNT_W(CNT_W)) u_tag_fifo (
    .clk     (clock_clk),
    .rst_n   (clock_sreset_reset_n),
    .push_i  (push),
    .din_i   (gnt1),
    .pop_i   (pop),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A read may only compete while a tag slot is free; writes always may.
  assign m0_elig = m0_write | (m0_read & ~fifo_full);
  assign m1_elig = m1_write | (m1_read & ~fifo_full);

  assign gnt1      = (state_q == GRANT1);
  assign gnt_any   = (state_q != IDLE);
  assign sel_read  = gnt1 ? m1_read  : m0_read;
  assign sel_write = gnt1 ? m1_write : m0_write;
  assign oth_read  = gnt1 ? m0_read  : m1_read;
  assign oth_write = gnt1 ? m0_write : m1_write;

  assign s_address    = gnt1 ? m1_address    : m0_address;
  assign s_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign s_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign s_read       = gnt_any & sel_read & ~fifo_full;
  assign s_write      = gnt_any & sel_write;

  assign accept         = (s_read | s_write) & ~s_waitrequest;
  assign m0_waitrequest = ~(accept & (state_q == GRANT0));
  assign m1_waitrequest = ~(accept & gnt1);

  assign push = accept & s_read;
  assign pop  = s_readdatavalid & ~fifo_empty;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head_id;
  assign m1_readdatavalid = pop & head_id;
  assign err_orphan       = err_q;

  // Fullness as it will be after this cycle's push/pop, for the back-to-back handoff.
  assign full_after     = (fifo_full & ~pop) | ((fifo_count == LAST_FREE) & push & ~pop);
  assign oth_elig_after = oth_write | (oth_read & ~full_after);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (m0_elig && m1_elig) state_d = rr_ptr_q ? GRANT1 : GRANT0;
        else if (m0_elig)       state_d = GRANT0;
        else if (m1_elig)       state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!(sel_read || sel_write)) begin
          state_d = IDLE;
        end else if (accept) begin
          rr_ptr_d = ~gnt1;
          state_d  = oth_elig_after ? (gnt1 ? GRANT0 : GRANT1) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clock_clk or negedge clock_sreset_reset_n) begin
    if (!clock_sreset_reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_q | (s_readdatavalid & fifo_empty);
    end
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Randomised bench for sdram_rr_arbiter against a queue-based transaction model.
module tb_sdram_rr_arbiter;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_PEND = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              s_waitrequest, s_readdatavalid, err_orphan;

  sdram_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clock_clk(clk), .clock_sreset_reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master command holders: a command stays up until the model says it was accepted.
  bit                act   [2];
  bit                is_rd [2];
  logic [ADDR_W-1:0] adr   [2];
  logic [DATA_W-1:0] wdat  [2];
  logic [BE_W-1:0]   ben   [2];
  int                p_req [2];
  int                p_rd  [2];
  int                p_wait, p_ret, p_drop;
  bit                orphan_now;
  int                ctl_out;

  // Reference model: granted master (-1 none), round-robin preference, ID queue, sticky error.
  int  gnt;
  bit  rr;
  int  pend[$];
  bit  err;

  task automatic model_reset();
    gnt = -1;
    rr  = 1'b0;
    pend.delete();
    err = 1'b0;
  endtask

  task automatic apply_inputs();
    m0_read = act[0] & is_rd[0];  m0_write = act[0] & ~is_rd[0];
    m1_read = act[1] & is_rd[1];  m1_write = act[1] & ~is_rd[1];
    m0_address = adr[0];  m0_writedata = wdat[0];  m0_byteenable = ben[0];
    m1_address = adr[1];  m1_writedata = wdat[1];  m1_byteenable = ben[1];
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (act[i] && $urandom_range(0, 999) < p_drop) begin
        act[i] = 1'b0;
      end else if (!act[i] && $urandom_range(0, 99) < p_req[i]) begin
        act[i]   = 1'b1;
        is_rd[i] = ($urandom_range(0, 99) < p_rd[i]);
        adr[i]   = ADDR_W'($urandom);
        wdat[i]  = DATA_W'($urandom);
        ben[i]   = BE_W'($urandom);
      end
    end
    apply_inputs();
    s_waitrequest   = ($urandom_range(0, 99) < p_wait);
    s_readdatavalid = orphan_now || (ctl_out > 0 && $urandom_range(0, 99) < p_ret);
    s_readdata      = DATA_W'($urandom);
  endtask

  task automatic step();
    bit r[2], w[2];
    bit full, full_after, e_sr, e_sw, acc, pop, e0, e1;
    int cnt, head, o;
    @(negedge clk);
    drive();
    #1;
    r[0] = m0_read;  w[0] = m0_write;  r[1] = m1_read;  w[1] = m1_write;
    cnt  = pend.size();
    full = (cnt == MAX_PEND);
    e_sr = 1'b0;  e_sw = 1'b0;
    if (gnt >= 0) begin
      e_sr = r[gnt] && !full;
      e_sw = w[gnt];
    end
    acc  = (e_sr || e_sw) && !s_waitrequest;
    pop  = s_readdatavalid && cnt > 0;
    head = pop ? pend[0] : 0;

    check("s_read",  s_read,  e_sr);
    check("s_write", s_write, e_sw);
    if (e_sr || e_sw) check("s_address", s_address, adr[gnt]);
    if (e_sw) begin
      check("s_writedata",  s_writedata,  wdat[gnt]);
      check("s_byteenable", s_byteenable, ben[gnt]);
    end
    check("m0_waitrequest",   m0_waitrequest,   !(gnt == 0 && acc));
    check("m1_waitrequest",   m1_waitrequest,   !(gnt == 1 && acc));
    check("m0_readdatavalid", m0_readdatavalid, pop && head == 0);
    check("m1_readdatavalid", m1_readdatavalid, pop && head == 1);
    check("m0_readdata",      m0_readdata,      s_readdata);
    check("m1_readdata",      m1_readdata,      s_readdata);
    check("err_orphan",       err_orphan,       err);

    @(posedge clk);
    if (s_readdatavalid) begin
      if (cnt == 0) err = 1'b1;
      else          void'(pend.pop_front());
      if (ctl_out > 0) ctl_out--;
    end
    if (acc) begin
      if (e_sr) begin
        pend.push_back(gnt);
        ctl_out++;
      end
      act[gnt] = 1'b0;
    end
    if (gnt < 0) begin
      e0 = w[0] || (r[0] && !full);
      e1 = w[1] || (r[1] && !full);
      if (e0 && e1)  gnt = rr ? 1 : 0;
      else if (e0)   gnt = 0;
      else if (e1)   gnt = 1;
    end else if (!(r[gnt] || w[gnt])) begin
      gnt = -1;
    end else if (acc) begin
      o          = 1 - gnt;
      rr         = (o == 1);
      full_after = (pend.size() == MAX_PEND);
      gnt        = (w[o] || (r[o] && !full_after)) ? o : -1;
    end
    orphan_now = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_s_read",   s_read,           1'b0);
    check("rst_s_write",  s_write,          1'b0);
    check("rst_m0_wait",  m0_waitrequest,   1'b1);
    check("rst_m1_wait",  m1_waitrequest,   1'b1);
    check("rst_m0_rdv",   m0_readdatavalid, 1'b0);
    check("rst_m1_rdv",   m1_readdatavalid, 1'b0);
    check("rst_err",      err_orphan,       1'b0);
    model_reset();
    repeat (cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic knobs(input int rq0, input int rd0, input int rq1, input int rd1,
                       input int wt, input int rt, input int dr);
    p_req[0] = rq0;  p_rd[0] = rd0;  p_req[1] = rq1;  p_rd[1] = rd1;
    p_wait = wt;  p_ret = rt;  p_drop = dr;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;  is_rd[i] = 1'b0;  adr[i] = '0;  wdat[i] = '0;  ben[i] = '0;
    end
    apply_inputs();
    s_waitrequest = 1'b0;  s_readdatavalid = 1'b0;  s_readdata = '0;
    orphan_now = 1'b0;  ctl_out = 0;
    rst_n = 1'b1;
    knobs(0, 0, 0, 0, 0, 0, 0);
    do_reset(3);

    knobs(30, 100, 0, 0, 0, 40, 0);      // m0 reads only, quick returns
    repeat (200) step();
    knobs(100, 0, 100, 0, 0, 0, 0);      // both masters streaming writes
    repeat (200) step();
    knobs(100, 100, 60, 0, 0, 0, 0);     // fill the tag FIFO, m1 writes keep flowing
    repeat (100) step();
    knobs(100, 100, 60, 50, 0, 25, 0);
    repeat (200) step();
    knobs(70, 50, 70, 50, 60, 30, 5);    // heavy controller stall, rare dropped requests
    repeat (2000) step();

    knobs(0, 0, 0, 0, 0, 100, 0);        // drain, then inject orphan returns
    repeat (60) step();
    for (int k = 0; k < 3; k++) begin
      orphan_now = 1'b1;
      step();
      repeat (5) step();
    end

    knobs(80, 60, 80, 60, 20, 10, 0);    // reset in the middle of traffic
    repeat (150) step();
    do_reset(2);
    repeat (600) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
